// File: rtl/stream_demux1hot_pkg.sv
// Shared constants and select-decode helpers for the one-hot stream demux.
package stream_demux1hot_pkg;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
  localparam int                   SEL_MAX_W   = 64;

  // Selects are zero-extended to SEL_MAX_W; only the low w bits are examined.
  function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] sel, input int w);
    int cnt;
    cnt = 0;
    for (int i = 0; i < SEL_MAX_W; i++)
      if (i < w && sel[i]) cnt++;
    return (cnt == 1);
  endfunction

  function automatic logic is_zero(input logic [SEL_MAX_W-1:0] sel, input int w);
    logic any;
    any = 1'b0;
    for (int i = 0; i < SEL_MAX_W; i++)
      if (i < w) any = any | sel[i];
    return ~any;
  endfunction

endpackage

// File: rtl/stream_demux1hot_slot.sv
// One-entry valid/data register slot; free when empty or being popped this cycle.
module stream_demux1hot_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             free,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    free    = ~valid_q | out_ready;
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    if (push) begin
      valid_d = 1'b1;
      data_d  = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/stream_demux1hot.sv
// One-hot stream demultiplexer with per-output register slots and illegal-select counter.
// Define STREAM_DEMUX1HOT_BCAST_EN to let multi-hot selects broadcast to every selected output.
module stream_demux1hot
  import stream_demux1hot_pkg::*;
#(
  parameter int OUTPUTS = 2,
  parameter int WIDTH   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [OUTPUTS-1:0]         in_sel,
  output logic [OUTPUTS-1:0]         out_valid,
  input  logic [OUTPUTS-1:0]         out_ready,
  output logic [WIDTH*OUTPUTS-1:0]   out_data,
  input  logic                       err_clr,
  output logic [ERR_CNT_W-1:0]       err_cnt
);

  logic [OUTPUTS-1:0]   free, push;
  logic [SEL_MAX_W-1:0] sel_wide;
  logic                 sel_legal, hs, err_evt;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // in_ready never looks at in_valid; illegal beats are always swallowed.
  always_comb begin
    sel_wide              = '0;
    sel_wide[OUTPUTS-1:0] = in_sel;
`ifdef STREAM_DEMUX1HOT_BCAST_EN
    sel_legal = ~is_zero(sel_wide, OUTPUTS);
    in_ready  = ~rst & (~sel_legal | (&(~in_sel | free)));
`else
    sel_legal = is_onehot(sel_wide, OUTPUTS);
    in_ready  = ~rst & (~sel_legal | (|(in_sel & free)));
`endif
    hs      = in_valid & in_ready;
    push    = (hs & sel_legal) ? in_sel : '0;
    err_evt = hs & ~sel_legal;

    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = err_evt ? ERR_CNT_W'(1) : '0;
    else if (err_evt && err_cnt_q != ERR_CNT_MAX)
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

  for (genvar i = 0; i < OUTPUTS; i++) begin : g_slot
    stream_demux1hot_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (in_data),
      .out_ready (out_ready[i]),
      .free      (free[i]),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_stream_demux1hot.sv
// Randomized and directed self-checking bench for stream_demux1hot (OUTPUTS=4, WIDTH=8).
module tb_stream_demux1hot;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, err_clr;
  logic [7:0]  in_data, err_cnt;
  logic [3:0]  in_sel, out_valid, out_ready;
  logic [31:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  bit         m_valid[4];
  logic [7:0] m_data[4];
  int         m_err;

  stream_demux1hot #(.OUTPUTS(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_clr(err_clr),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: per-lane holding register as plain arrays, legality by popcount.
  function automatic bit m_legal();
`ifdef STREAM_DEMUX1HOT_BCAST_EN
    return $countones(in_sel) >= 1;
`else
    return $countones(in_sel) == 1;
`endif
  endfunction

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (!m_legal()) return 1'b1;
    for (int i = 0; i < 4; i++)
      if (in_sel[i] && m_valid[i] && !out_ready[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = m_data[i];
    return d;
  endfunction

  task automatic model_edge();
    bit hs, legal;
    hs    = in_valid && m_ready();
    legal = m_legal();
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_data[i] = 8'h00; end
      m_err = 0;
      return;
    end
    for (int i = 0; i < 4; i++) if (out_ready[i]) m_valid[i] = 0;
    if (hs && legal)
      for (int i = 0; i < 4; i++)
        if (in_sel[i]) begin m_valid[i] = 1; m_data[i] = in_data; end
    if (err_clr) m_err = (hs && !legal) ? 1 : 0;
    else if (hs && !legal && m_err < 255) m_err++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    in_valid = 0; err_clr = 0; out_ready = 4'hF;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_sel = 4'b0001; in_data = 8'h5A; out_ready = 4'hF; err_clr = 0;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tick(); tick();
    n_tests++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", out_data); end
    n_tests++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
    rst = 0; in_valid = 0;
  endtask

  task automatic test_routing();
    logic [3:0] sels[3] = '{4'b0001, 4'b0100, 4'b1000};
    logic [7:0] dats[3] = '{8'h11, 8'h22, 8'h33};
    int         lanes[3] = '{0, 2, 3};
    drain();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_sel = sels[k]; in_data = dats[k];
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL route_ready%0d got=%b exp=1", k, in_ready); end
      tick();
      n_tests++; if (out_valid !== sels[k]) begin n_fail++; $display("FAIL route_valid%0d got=%b exp=%b", k, out_valid, sels[k]); end
      n_tests++; if (out_data[lanes[k]*8 +: 8] !== dats[k]) begin n_fail++; $display("FAIL route_data%0d got=%h exp=%h", k, out_data[lanes[k]*8 +: 8], dats[k]); end
    end
    n_tests++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL route_err got=%0d exp=0", err_cnt); end
    in_valid = 0;
  endtask

  task automatic test_backpressure();
    drain();
    out_ready = 4'b1101; in_valid = 1; in_sel = 4'b0010; in_data = 8'hA0;
    tick();
    in_data = 8'hA1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_blocked got=%b exp=0", in_ready); end
    tick();
    n_tests++; if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'hA0) begin n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/a0", out_valid[1], out_data[15:8]); end
    in_sel = 4'b0001; in_data = 8'hB0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready got=%b exp=1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 4'b0011 || out_data[7:0] !== 8'hB0) begin n_fail++; $display("FAIL bp_other got=%b/%h exp=0011/b0", out_valid, out_data[7:0]); end
    out_ready = 4'hF; in_sel = 4'b0010; in_data = 8'hA1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'hA1) begin n_fail++; $display("FAIL bp_release got=%b/%h exp=0010/a1", out_valid, out_data[15:8]); end
    in_valid = 0;
  endtask

  task automatic test_streaming();
    drain();
    in_valid = 1; in_sel = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      in_data = 8'(k);
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d got=%b exp=1", k, in_ready); end
      tick();
      n_tests++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'(k)) begin n_fail++; $display("FAIL stream_beat%0d got=%b/%h exp=0100/%h", k, out_valid, out_data[23:16], 8'(k)); end
    end
    in_valid = 0;
    tick();
    n_tests++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL stream_end got=%b exp=0000", out_valid); end
  endtask

  task automatic test_illegal();
    drain();
    err_clr = 1; tick(); err_clr = 0;
    in_valid = 1; in_data = 8'hEE;
    for (int k = 0; k < 300; k++) begin
`ifdef STREAM_DEMUX1HOT_BCAST_EN
      in_sel = 4'b0000;
`else
      in_sel = (k % 2 == 0) ? 4'b0000 : 4'b0110;
`endif
      #1;
      if (k < 3) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready%0d got=%b exp=1", k, in_ready); end
      end
      tick();
      n_tests++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL illegal_valid%0d got=%b exp=0000", k, out_valid); end
      if (k == 9) begin
        n_tests++; if (err_cnt !== 8'd10) begin n_fail++; $display("FAIL illegal_count got=%0d exp=10", err_cnt); end
      end
    end
    n_tests++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL illegal_sat got=%0d exp=255", err_cnt); end
    err_clr = 1; in_sel = 4'b0000;
    tick();
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_with_err got=%0d exp=1", err_cnt); end
    in_valid = 0;
    tick();
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_alone got=%0d exp=0", err_cnt); end
    err_clr = 0;
  endtask

`ifdef STREAM_DEMUX1HOT_BCAST_EN
  task automatic test_bcast();
    drain();
    err_clr = 1; tick(); err_clr = 0;
    out_ready = 4'b1011; in_valid = 1; in_sel = 4'b0100; in_data = 8'hC2;
    tick();
    in_sel = 4'b0110; in_data = 8'hC6;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_blocked got=%b exp=0", in_ready); end
    tick();
    out_ready = 4'hF;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_ready got=%b exp=1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 4'b0110 || out_data[15:8] !== 8'hC6 || out_data[23:16] !== 8'hC6) begin n_fail++; $display("FAIL bcast_both got=%b/%h exp=0110/c6c6", out_valid, out_data[23:8]); end
    in_sel = 4'b0000;
    tick();
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL bcast_zero_err got=%0d exp=1", err_cnt); end
    in_valid = 0;
  endtask
`endif

  task automatic test_reset_mid();
    drain();
    out_ready = 4'h0; in_valid = 1;
    in_sel = 4'b0001; in_data = 8'h40; tick();
    in_sel = 4'b1000; in_data = 8'h43; tick();
    in_sel = 4'b0000; tick();
    n_tests++; if (out_valid !== 4'b1001 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL rmid_setup got=%b/%0d exp=1001/1", out_valid, err_cnt); end
    rst = 1; in_sel = 4'b0010;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
    tick();
    rst = 0; in_valid = 0;
    n_tests++; if (out_valid !== 4'h0 || out_data !== 32'h0 || err_cnt !== 8'h0) begin n_fail++; $display("FAIL rmid_clear got=%b/%h/%0d exp=0/0/0", out_valid, out_data, err_cnt); end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      err_clr   = ($urandom_range(0, 31) == 0);
      #1;
      n_tests++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
      tick();
      n_tests++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, exp_valid()); end
      n_tests++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_data, exp_data()); end
      n_tests++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL rand_err c=%0d got=%0d exp=%0d", c, err_cnt, m_err); end
    end
    in_valid = 0; err_clr = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_data[i] = 8'h00; end
    m_err = 0;
    test_reset();
    test_routing();
    test_backpressure();
    test_streaming();
    test_illegal();
`ifdef STREAM_DEMUX1HOT_BCAST_EN
    test_bcast();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux1hot.md
# stream_demux1hot

One-hot stream demultiplexer: accepts a single valid/ready input stream and routes each beat to exactly one of OUTPUTS output streams under a one-hot destination select, through a one-entry register slot per output. It is the distribution-side counterpart of the one-hot mux. It sits after a producer that fans out to several consumers, such as dispatch to execution lanes, and its packed output bus uses the same lane ordering as the mux input bus.

## Interface
- OUTPUTS, default 2: number of output streams (≥2).
- WIDTH, default 1: data width per beat.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  WIDTH  input payload.
- in_sel  in  OUTPUTS  one-hot destination; bit i selects output i; sampled with in_data.
- out_valid  out  OUTPUTS  per-output valid.
- out_ready  in  OUTPUTS  per-output ready.
- out_data  out  WIDTH*OUTPUTS  packed payloads; output i at [i*WIDTH +: WIDTH].
- err_clr  in  1  clears err_cnt.
- err_cnt  out  8  saturating count of illegal-select beats.

## Operation
- Each output i has one register slot holding valid and data.
- The slot is free when ~out_valid[i] | out_ready[i], so a same-cycle pop and push is allowed.
- A legal select is exactly one bit set.
  - in_ready = |(in_sel & free).
  - On the handshake, the selected slot loads in_data and sets valid.
- A slot whose beat is popped and not refilled clears valid. out_data holds its last value.
- Illegal select, without broadcast: zero-hot or multi-hot.
  - in_ready = 1 and the beat is discarded.
  - No slot changes.
  - err_cnt increments, saturating at 255.
- err_clr has priority over the increment on the register input. Clear and error in the same cycle gives err_cnt = 1. Clear alone gives 0.
- in_ready depends combinationally on in_sel, in_valid-independent terms and out_ready. There is no combinational path from in_valid to in_ready.
- Per-output ordering is preserved. There is no ordering across outputs.

## Timing
- Latency: a beat accepted at edge t appears on out_valid/out_data from t+1.
- Throughput: 1 beat/cycle per output while out_ready stays high.
- Reset: out_valid = 0, out_data = 0, err_cnt = 0.
  - Held or in-flight beats are dropped.
  - While rst is high, in_ready = 0.
- Backpressure on output j never blocks beats selected to output k≠j.
- A full slot with out_ready low holds its data stable. Valid must not drop without a handshake.

## Configuration
- STREAM_DEMUX1HOT_BCAST_EN defined:
  - A multi-hot in_sel broadcasts.
  - in_ready = &(~in_sel | free), meaning all selected slots are free.
  - All selected slots load in_data in the same cycle.
  - Only zero-hot counts as illegal; it is accepted, discarded and counted.
- Undefined: multi-hot is illegal, as described under Operation.
- The port list is identical in both builds.

## Structure
- Package stream_demux1hot_pkg holds:
  - ERR_CNT_W = 8 and ERR_CNT_MAX.
  - Functions is_onehot(sel) and is_zero(sel), parameterised through a wide packed argument plus width.
- One sub-module, stream_demux1hot_slot: a one-entry valid/data register with push, pop and free. It is instantiated OUTPUTS times.
- Top level: select decode, in_ready generation, error counter. Target 150–250 lines total.

## Test plan
- Basic routing:
  - Stimulus: OUTPUTS=4, WIDTH=8, all out_ready=1, beats 0x11/sel=0001, 0x22/0100, 0x33/1000 on consecutive cycles.
  - Response: each appears on lanes 0, 2, 3 exactly one cycle after acceptance; err_cnt=0.
- Backpressure isolation:
  - Stimulus: out_ready[1]=0, send 0xA0 to lane 1, then 0xA1 to lane 1, then 0xB0 to lane 0.
  - Response: 0xA0 held; in_ready=0 for 0xA1; when presented, 0xB0 is accepted and delivered next cycle; raising out_ready[1] drains 0xA0 and accepts 0xA1 in the same cycle.
- Streaming:
  - Stimulus: lane 2 out_ready=1 continuously, 16 back-to-back beats 0x00..0x0F.
  - Response: 16 outputs in order; in_ready stays 1; no bubbles.
- Illegal select, non-BCAST build:
  - Stimulus: sel=0000, then sel=0110, 300 times.
  - Response: beats accepted and discarded; no out_valid; err_cnt saturates at 255.
  - Stimulus: err_clr together with an illegal beat.
  - Response: err_cnt=1.
- Broadcast, BCAST build:
  - Stimulus: sel=0110 with out_ready[2]=0 and lane 2 full.
  - Response: in_ready=0; after lane 2 drains, lanes 1 and 2 both show the beat next cycle; sel=0000 increments err_cnt.
- Reset mid-operation:
  - Stimulus: lanes 0 and 3 full with out_ready=0, assert rst for 1 cycle.
  - Response: next cycle out_valid=0000, out_data=0, err_cnt=0, and in_ready=0 during rst.
